// File: rtl/diferenca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diferenca_pkg
// Purpose  : Shared FSM encoding and width helper for the SAD accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package diferenca_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ACUMULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Ceiling log2; used to size the SAD so a full frame of maxima cannot overflow.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/diferenca_abs.sv
`default_nettype none
// ============================================================================
// Module   : diferenca_abs
// Purpose  : Combinational unsigned |A-B| with sign flag (1 when A<B).
// Revision : 1.0 - initial release
// ============================================================================
module diferenca_abs #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_dif,
    output logic             o_sinal
);

    logic w_menor;

    assign w_menor = (i_a < i_b);
    assign o_sinal = w_menor;
    assign o_dif   = w_menor ? (i_b - i_a) : (i_a - i_b);

endmodule
`default_nettype wire

// File: rtl/diferenca_acumulada.sv
`default_nettype none
// ============================================================================
// Module   : diferenca_acumulada
// Purpose  : Streamed |A-B| with registered output and per-frame SAD.
// Revision : 1.0 - initial release
// ============================================================================
module diferenca_acumulada
    import diferenca_pkg::*;
#(
    parameter  int WIDTH      = 4,
    parameter  int N_AMOSTRAS = 8,
    localparam int ACC_W      = WIDTH + clog2(N_AMOSTRAS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dif,
    output logic             sinal,
    output logic             soma_valid,
    output logic [ACC_W-1:0] soma
);

    localparam int                 c_cnt_w  = clog2(N_AMOSTRAS);
    localparam logic [c_cnt_w-1:0] c_ultima = c_cnt_w'(N_AMOSTRAS - 1);
    localparam logic [c_cnt_w-1:0] c_um     = c_cnt_w'(1);

    logic [WIDTH-1:0]   w_dif;
    logic               w_sinal;
    logic [ACC_W-1:0]   w_dif_ext;
    logic               w_ready;
    logic               w_accept;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_dif;
    logic               r_sinal;
    logic               r_soma_valid;
    logic [ACC_W-1:0]   r_soma;
    logic [ACC_W-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_count;
    estado_t            r_estado;

    diferenca_abs #(
        .WIDTH (WIDTH)
    ) u_abs (
        .i_a     (A),
        .i_b     (B),
        .o_dif   (w_dif),
        .o_sinal (w_sinal)
    );

    assign w_dif_ext = {{(ACC_W - WIDTH){1'b0}}, w_dif};
    assign w_ready   = ~clear & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & w_ready;
    // Flops are already held in reset, so rst_n only needs to mask the port.
    assign in_ready  = rst_n & w_ready;

    assign out_valid  = r_out_valid;
    assign dif        = r_dif;
    assign sinal      = r_sinal;
    assign soma_valid = r_soma_valid;
    assign soma       = r_soma;

    // 1-deep output register; clear never touches it so a pending sample drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dif       <= '0;
            r_sinal     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_dif       <= w_dif;
            r_sinal     <= w_sinal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= ESPERA;
            r_acc        <= '0;
            r_count      <= '0;
            r_soma       <= '0;
            r_soma_valid <= 1'b0;
        end else if (clear) begin
            r_estado     <= ESPERA;
            r_acc        <= '0;
            r_count      <= '0;
            r_soma_valid <= 1'b0;
        end else begin
            r_soma_valid <= 1'b0;
            case (r_estado)
                ESPERA, FIM: begin
                    r_acc   <= '0;
                    r_count <= '0;
                    if (w_accept) begin
                        r_acc    <= w_dif_ext;
                        r_count  <= c_um;
                        r_estado <= ACUMULA;
                    end else begin
                        r_estado <= ESPERA;
                    end
                end
                ACUMULA: begin
                    if (w_accept) begin
                        if (r_count == c_ultima) begin
                            r_soma       <= r_acc + w_dif_ext;
                            r_soma_valid <= 1'b1;
                            r_acc        <= '0;
                            r_count      <= '0;
                            r_estado     <= FIM;
                        end else begin
                            r_acc   <= r_acc + w_dif_ext;
                            r_count <= r_count + c_um;
                        end
                    end
                end
                default: begin
                    r_estado <= ESPERA;
                    r_acc    <= '0;
                    r_count  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diferenca_acumulada.sv
`default_nettype none
// ============================================================================
// Module   : tb_diferenca_acumulada
// Purpose  : Directed self-checking bench for diferenca_acumulada.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diferenca_acumulada;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  dif;
    logic        sinal;
    logic        soma_valid;
    logic [6:0]  soma;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  A2;
    logic [7:0]  B2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  dif2;
    logic        sinal2;
    logic        soma_valid2;
    logic [11:0] soma2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] t4_a [8] = '{4'd3, 4'd0, 4'd10, 4'd7, 4'd15, 4'd1, 4'd4, 4'd9};
    logic [3:0] t4_b [8] = '{4'd1, 4'd5, 4'd2,  4'd7, 4'd0,  4'd14, 4'd6, 4'd9};
    logic [3:0] t4_d [8] = '{4'd2, 4'd5, 4'd8,  4'd0, 4'd15, 4'd13, 4'd2, 4'd0};
    logic       t4_s [8] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b0,  1'b1,  1'b1, 1'b0};

    always #5 clk = ~clk;

    diferenca_acumulada #(
        .WIDTH      (4),
        .N_AMOSTRAS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dif        (dif),
        .sinal      (sinal),
        .soma_valid (soma_valid),
        .soma       (soma)
    );

    diferenca_acumulada #(
        .WIDTH      (8),
        .N_AMOSTRAS (16)
    ) dut_larga (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (1'b0),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .A          (A2),
        .B          (B2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .dif        (dif2),
        .sinal      (sinal2),
        .soma_valid (soma_valid2),
        .soma       (soma2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; A2 = '0; B2 = '0; out_ready2 = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dif", dif, 0);
        chk("rst_sinal", sinal, 0);
        chk("rst_soma_valid", soma_valid, 0);
        chk("rst_soma", soma, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic arithmetic, one cycle after accept
        in_valid = 1'b1; A = 4'd9; B = 4'd3;
        #1 chk("t1_in_ready", in_ready, 1);
        tick(); chk("t1a_valid", out_valid, 1); chk("t1a_dif", dif, 6); chk("t1a_sinal", sinal, 0);
        A = 4'd3; B = 4'd9;
        tick(); chk("t1b_dif", dif, 6); chk("t1b_sinal", sinal, 1);
        A = 4'd7; B = 4'd7;
        tick(); chk("t1c_dif", dif, 0); chk("t1c_sinal", sinal, 0);
        A = 4'd0; B = 4'd15;
        tick(); chk("t1d_dif", dif, 15); chk("t1d_sinal", sinal, 1); chk("t1_soma_valid", soma_valid, 0);

        // Clear abandons the partial frame and refuses the simultaneous sample
        clear = 1'b1; A = 4'd15; B = 4'd0;
        #1 chk("clr_in_ready", in_ready, 0);
        tick(); chk("clr_not_accepted", out_valid, 0); chk("clr_soma_valid", soma_valid, 0);
        chk("clr_soma", soma, 0);
        clear = 1'b0;

        // Full frame of maxima
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_dif", dif, 15);
            chk("t2_pulse", soma_valid, (i == 7));
            chk("t2_soma", soma, (i == 7) ? 120 : 0);
        end
        A = 4'd2; B = 4'd0;
        tick(); chk("t2_pulse_end", soma_valid, 0); chk("t2_soma_held", soma, 120); chk("t2_ninth_dif", dif, 2);
        in_valid = 1'b0;
        tick(); chk("t2_drain", out_valid, 0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; A = 4'd5; B = 4'd1;
        #1 chk("t3_ready_first", in_ready, 1);
        tick(); chk("t3_valid", out_valid, 1); chk("t3_dif", dif, 4); chk("t3_ready_stall", in_ready, 0);
        A = 4'd1; B = 4'd6;
        repeat (4) begin
            tick();
            chk("t3_hold_dif", dif, 4); chk("t3_hold_sinal", sinal, 0);
            chk("t3_hold_valid", out_valid, 1); chk("t3_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("t3_release_ready", in_ready, 1);
        tick(); chk("t3_next_dif", dif, 5); chk("t3_next_sinal", sinal, 1);
        A = 4'd8; B = 4'd8;
        tick(); chk("t3_last_dif", dif, 0); chk("t3_last_valid", out_valid, 1);

        // Clear on a mid-frame sample; following frame must start from zero
        A = 4'd4; B = 4'd0; clear = 1'b1;
        #1 chk("t4_clr_ready", in_ready, 0);
        tick(); chk("t4_not_accepted", out_valid, 0); chk("t4_soma_valid", soma_valid, 0);
        chk("t4_soma_kept", soma, 120);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A = t4_a[i]; B = t4_b[i];
            tick();
            chk("t4_dif", dif, t4_d[i]);
            chk("t4_sinal", sinal, t4_s[i]);
            chk("t4_pulse", soma_valid, (i == 7));
            chk("t4_soma", soma, (i == 7) ? 45 : 120);
        end
        in_valid = 1'b0;
        tick(); chk("t4_pulse_end", soma_valid, 0); chk("t4_soma_held", soma, 45);

        // Asynchronous reset mid-frame
        in_valid = 1'b1; A = 4'd15; B = 4'd0;
        repeat (3) tick();
        chk("t5_pre_valid", out_valid, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0); chk("t5_dif", dif, 0); chk("t5_sinal", sinal, 0);
        chk("t5_soma", soma, 0); chk("t5_soma_valid", soma_valid, 0); chk("t5_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; A = 4'd6; B = 4'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_pulse", soma_valid, (i == 7));
            chk("t5_soma_frame", soma, (i == 7) ? 40 : 0);
        end
        in_valid = 1'b0;
        tick();

        // Wide instance: full-scale frame fits ACC_W exactly
        in_valid2 = 1'b1; A2 = 8'd255; B2 = 8'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t6_pulse", soma_valid2, (i == 15));
        end
        chk("t6_soma", soma2, 4080);
        chk("t6_dif", dif2, 255);
        in_valid2 = 1'b0;
        tick(); chk("t6_pulse_end", soma_valid2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
